axilite_m_bridge: RTL and testbench
===================================

AXILITE_M_BRIDGE -- requirements
Module: axilite_m_bridge

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12, AXI address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, fixed data width; other values are unsupported.
REQ-003 SHALL have parameter TIMEOUT, default 256, maximum cycles spent waiting on any AXI handshake.
REQ-004 SHALL use one clock and an asynchronous, active-low reset; ports listed below.
REQ-005 axi_aclk  in  1  clock; all logic on the rising edge.
REQ-006 axi_aresetn  in  1  asynchronous active-low reset.
REQ-007 cmd_valid/cmd_ready  in/out  1  command handshake.
REQ-008 cmd_write  in  1  1 = write, 0 = read.
REQ-009 cmd_addr  in  ADDR_WIDTH  byte address; cmd_wdata  in  32  write data; cmd_wstrb  in  4  byte strobes.
REQ-010 rsp_valid/rsp_ready  out/in  1  response handshake.
REQ-011 rsp_write  out  1  echoes cmd_write; rsp_rdata  out  32  read data (0 for writes); rsp_resp  out  2  AXI response code.
REQ-012 AXI-Lite master ports: awvalid, awready, awaddr, awprot; wvalid, wready, wdata, wstrb; bvalid, bready, bresp; arvalid, arready, araddr, arprot; rvalid, rready, rdata, rresp. Widths follow AXI4-Lite.

Function
REQ-013 FSM states SHALL be IDLE, WR, WR_B, RD_AR, RD_R, RSP.
REQ-014 Only one transaction SHALL be outstanding at a time.
REQ-015 cmd_ready SHALL be 1 only in IDLE; a command is accepted when cmd_valid & cmd_ready.
REQ-016 On an accepted write, SHALL register addr/data/strb and enter WR; awvalid and wvalid SHALL both assert the next cycle.
REQ-017 In WR, awvalid SHALL drop after its own handshake and wvalid after its own; either may complete first, or both in the same cycle. Both SHALL complete before moving to WR_B.
REQ-018 In WR_B, bready SHALL be 1; on bvalid, SHALL capture bresp and go to RSP.
REQ-019 On an accepted read, SHALL enter RD_AR with arvalid=1; on arready, go to RD_R with rready=1; on rvalid, capture rdata/rresp and go to RSP.
REQ-020 awprot and arprot SHALL be constant 3'b000.
REQ-021 AXI valid signals SHALL NOT deassert before their handshake, except on timeout; addr/data SHALL be stable while valid.
REQ-022 In RSP, rsp_valid SHALL be 1 and payload stable until rsp_ready; then return to IDLE.
REQ-023 Command-accept to AXI valid latency SHALL be 1 cycle; last AXI handshake to rsp_valid latency SHALL be 1 cycle.
REQ-024 A wait counter SHALL clear on each state entry and increment each cycle in WR, WR_B, RD_AR, RD_R.
REQ-025 When the counter reaches TIMEOUT-1, SHALL drop all AXI valid/ready signals, set rsp_resp=2'b11 (DECERR) and rsp_rdata=0, and go to RSP.
REQ-026 A late bvalid or rvalid after a timeout SHALL be ignored; bready/rready SHALL be 0 outside WR_B/RD_R.
REQ-027 The counter SHALL saturate and never wrap.

Reset
REQ-028 While axi_aresetn=0: state=IDLE, counter=0, and all valid/ready outputs 0.
REQ-029 While axi_aresetn=0: all address, data and response registers 0, except cmd_ready, which becomes 1 after reset release.
REQ-030 Reset mid-transaction SHALL abandon the transaction with no response; outputs SHALL go to reset values asynchronously.

Structure
REQ-031 Package axilite_m_pkg SHALL hold the FSM state enum, response constants (OKAY=0, SLVERR=2, DECERR=3) and default widths.
REQ-032 No sub-module; the counter SHALL be inline.

Verification
REQ-033 Write 0x004 data 0xDEADBEEF strb 0xF; slave asserts awready before wready -> each valid held until its own handshake; rsp_resp=0, rsp_write=1.
REQ-034 Read 0x004 with slave returning 0xDEADBEEF after 3 wait cycles -> rsp_rdata=0xDEADBEEF, rsp_resp=0, 1-cycle response latency.
REQ-035 AW and W ready in the same cycle, bresp=2'b10 -> rsp_resp=2'b10 with no extra cycles.
REQ-036 Slave never asserts arready, TIMEOUT=16 -> arvalid drops after 16 cycles; rsp_resp=2'b11, rsp_rdata=0.
REQ-037 rsp_ready held 0 for 5 cycles -> payload stable, cmd_ready=0 throughout; the next command is accepted only after the rsp handshake.
REQ-038 axi_aresetn pulsed low during WR_B -> all valid/ready outputs 0 immediately; cmd_ready=1 after release; no rsp_valid.

Source files
------------

// File: rtl/axilite_m_pkg.sv
// Shared definitions for the AXI4-Lite master bridge.
//   state_e        : bridge FSM states
//   RESP_*         : AXI response codes
//   DEF_*          : default parameter values for the bridge and its bus interface
package axilite_m_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WR_B,
        RD_AR,
        RD_R,
        RSP
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int unsigned DEF_ADDR_WIDTH = 12;
    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_TIMEOUT    = 256;

endpackage

// File: rtl/axilite_m_bridge_if.sv
// AXI4-Lite bus bundle between the bridge (master) and a slave.
//   AW: awvalid/awready/awaddr/awprot   W: wvalid/wready/wdata/wstrb
//   B : bvalid/bready/bresp             AR: arvalid/arready/araddr/arprot
//   R : rvalid/rready/rdata/rresp
interface axilite_m_bridge_if
    import axilite_m_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
);
    logic                      awvalid;
    logic                      awready;
    logic [ADDR_WIDTH-1:0]     awaddr;
    logic [2:0]                awprot;
    logic                      wvalid;
    logic                      wready;
    logic [DATA_WIDTH-1:0]     wdata;
    logic [DATA_WIDTH/8-1:0]   wstrb;
    logic                      bvalid;
    logic                      bready;
    logic [1:0]                bresp;
    logic                      arvalid;
    logic                      arready;
    logic [ADDR_WIDTH-1:0]     araddr;
    logic [2:0]                arprot;
    logic                      rvalid;
    logic                      rready;
    logic [DATA_WIDTH-1:0]     rdata;
    logic [1:0]                rresp;

    modport master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

endinterface

// File: rtl/axilite_m_bridge.sv
// Single-outstanding command/response to AXI4-Lite master bridge.
//   axi_aclk, axi_aresetn          : clock, async active-low reset
//   cmd_valid/ready, cmd_write,
//   cmd_addr, cmd_wdata, cmd_wstrb : command in (write when cmd_write=1)
//   rsp_valid/ready, rsp_write,
//   rsp_rdata, rsp_resp            : response out (rdata 0 for writes, DECERR on timeout)
//   axi                            : AXI4-Lite master bus
module axilite_m_bridge
    import axilite_m_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                    axi_aclk,
    input  logic                    axi_aresetn,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_write,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,
    axilite_m_bridge_if.master      axi
);

    localparam int unsigned     CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    aw_pend_q, aw_pend_d;
    logic                    w_pend_q, w_pend_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [1:0]              resp_q, resp_d;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH/8-1:0] wstrb_q;
    logic                    write_q;
    logic                    init_q;
    logic                    cmd_fire;
    logic                    timeout;
    logic                    waiting;

    // init_q keeps cmd_ready low while reset is asserted and for the release edge.
    assign cmd_ready = init_q && (state_q == IDLE);
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign timeout   = (cnt_q == CNT_LAST);
    assign waiting   = (state_q == WR) || (state_q == WR_B) ||
                       (state_q == RD_AR) || (state_q == RD_R);

    always_comb begin
        state_d   = state_q;
        aw_pend_d = aw_pend_q;
        w_pend_d  = w_pend_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_fire) begin
                    if (cmd_write) begin
                        state_d   = WR;
                        aw_pend_d = 1'b1;
                        w_pend_d  = 1'b1;
                    end else begin
                        state_d = RD_AR;
                    end
                end
            end
            WR: begin
                // Each channel retires independently; both must finish to leave.
                aw_pend_d = aw_pend_q && !axi.awready;
                w_pend_d  = w_pend_q && !axi.wready;
                if (!aw_pend_d && !w_pend_d) begin
                    state_d = WR_B;
                end else if (timeout) begin
                    aw_pend_d = 1'b0;
                    w_pend_d  = 1'b0;
                    resp_d    = RESP_DECERR;
                    rdata_d   = '0;
                    state_d   = RSP;
                end
            end
            WR_B: begin
                if (axi.bvalid) begin
                    resp_d  = axi.bresp;
                    rdata_d = '0;
                    state_d = RSP;
                end else if (timeout) begin
                    resp_d  = RESP_DECERR;
                    rdata_d = '0;
                    state_d = RSP;
                end
            end
            RD_AR: begin
                if (axi.arready) begin
                    state_d = RD_R;
                end else if (timeout) begin
                    resp_d  = RESP_DECERR;
                    rdata_d = '0;
                    state_d = RSP;
                end
            end
            RD_R: begin
                if (axi.rvalid) begin
                    resp_d  = axi.rresp;
                    rdata_d = axi.rdata;
                    state_d = RSP;
                end else if (timeout) begin
                    resp_d  = RESP_DECERR;
                    rdata_d = '0;
                    state_d = RSP;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Wait counter: cleared on every state change, saturating otherwise.
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (waiting && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            aw_pend_q <= 1'b0;
            w_pend_q  <= 1'b0;
            rdata_q   <= '0;
            resp_q    <= RESP_OKAY;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            write_q   <= 1'b0;
            init_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            aw_pend_q <= aw_pend_d;
            w_pend_q  <= w_pend_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
            init_q    <= 1'b1;
            if (cmd_fire) begin
                addr_q  <= cmd_addr;
                wdata_q <= cmd_wdata;
                wstrb_q <= cmd_wstrb;
                write_q <= cmd_write;
            end
        end
    end

    assign axi.awvalid = aw_pend_q;
    assign axi.awaddr  = addr_q;
    assign axi.awprot  = 3'b000;
    assign axi.wvalid  = w_pend_q;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = wstrb_q;
    assign axi.bready  = (state_q == WR_B);
    assign axi.arvalid = (state_q == RD_AR);
    assign axi.araddr  = addr_q;
    assign axi.arprot  = 3'b000;
    assign axi.rready  = (state_q == RD_R);

    assign rsp_valid = (state_q == RSP);
    assign rsp_write = write_q;
    assign rsp_rdata = rdata_q;
    assign rsp_resp  = resp_q;

endmodule

// File: tb/tb_axilite_m_bridge.sv
// Directed self-checking bench for axilite_m_bridge (TIMEOUT=16).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_axilite_m_bridge;
    import axilite_m_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [11:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;

    int n_pass  = 0;
    int n_total = 0;

    axilite_m_bridge_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) axi ();

    axilite_m_bridge #(
        .ADDR_WIDTH(12),
        .DATA_WIDTH(32),
        .TIMEOUT   (16)
    ) dut (
        .axi_aclk   (clk),
        .axi_aresetn(rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .cmd_wstrb  (cmd_wstrb),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_write  (rsp_write),
        .rsp_rdata  (rsp_rdata),
        .rsp_resp   (rsp_resp),
        .axi        (axi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one command; returns on the falling edge after the accepting edge.
    task automatic send_cmd(input logic wr, input logic [11:0] addr,
                            input logic [31:0] data, input logic [3:0] strb);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = data;
        cmd_wstrb = strb;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [4:0] vr;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        vr = {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready};
        n_total++; if (vr !== 5'b0) $display("FAIL reset_axi_vr: got %b want 00000", vr);
        else n_pass++;
        n_total++; if (cmd_ready !== 1'b0) $display("FAIL reset_cmd_ready: got %b want 0", cmd_ready);
        else n_pass++;
        n_total++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid);
        else n_pass++;
        n_total++;
        if ({axi.awaddr, rsp_rdata, rsp_resp} !== 46'b0)
            $display("FAIL reset_regs: got %h/%h/%h want 0", axi.awaddr, rsp_rdata, rsp_resp);
        else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
        n_total++; if (cmd_ready !== 1'b1) $display("FAIL release_cmd_ready: got %b want 1", cmd_ready);
        else n_pass++;
    endtask

    // AW accepted first, W held two more cycles.
    task automatic test_write();
        send_cmd(1'b1, 12'h004, 32'hDEADBEEF, 4'hF);
        n_total++;
        if ({axi.awvalid, axi.wvalid} !== 2'b11)
            $display("FAIL wr_valid_latency: got %b want 11", {axi.awvalid, axi.wvalid});
        else n_pass++;
        n_total++;
        if ({axi.awaddr, axi.wdata, axi.wstrb, axi.awprot} !== {12'h004, 32'hDEADBEEF, 4'hF, 3'b000})
            $display("FAIL wr_payload: got %h %h %h %h", axi.awaddr, axi.wdata, axi.wstrb, axi.awprot);
        else n_pass++;
        axi.awready = 1'b1;
        @(negedge clk);
        axi.awready = 1'b0;
        n_total++;
        if ({axi.awvalid, axi.wvalid} !== 2'b01)
            $display("FAIL wr_aw_first: got %b want 01", {axi.awvalid, axi.wvalid});
        else n_pass++;
        @(negedge clk);
        n_total++;
        if ({axi.wvalid, axi.wdata} !== {1'b1, 32'hDEADBEEF})
            $display("FAIL wr_w_held: got %b %h want 1 deadbeef", axi.wvalid, axi.wdata);
        else n_pass++;
        axi.wready = 1'b1;
        @(negedge clk);
        axi.wready = 1'b0;
        n_total++;
        if ({axi.wvalid, axi.bready} !== 2'b01)
            $display("FAIL wr_to_b: got %b want 01", {axi.wvalid, axi.bready});
        else n_pass++;
        axi.bvalid = 1'b1;
        axi.bresp  = RESP_OKAY;
        @(negedge clk);
        axi.bvalid = 1'b0;
        n_total++;
        if ({rsp_valid, rsp_write, rsp_resp, rsp_rdata, axi.bready} !== {2'b11, 2'b00, 32'h0, 1'b0})
            $display("FAIL wr_rsp: got v%b w%b r%h d%h b%b want v1 w1 r0 d0 b0",
                     rsp_valid, rsp_write, rsp_resp, rsp_rdata, axi.bready);
        else n_pass++;
        finish_rsp();
        n_total++;
        if ({rsp_valid, cmd_ready} !== 2'b01)
            $display("FAIL wr_idle: got %b want 01", {rsp_valid, cmd_ready});
        else n_pass++;
    endtask

    // Slave inserts three wait cycles before rvalid.
    task automatic test_read();
        send_cmd(1'b0, 12'h004, 32'h0, 4'h0);
        n_total++;
        if ({axi.arvalid, axi.araddr, axi.arprot, axi.rready} !== {1'b1, 12'h004, 3'b000, 1'b0})
            $display("FAIL rd_ar: got v%b a%h p%h r%b want v1 a004 p0 r0",
                     axi.arvalid, axi.araddr, axi.arprot, axi.rready);
        else n_pass++;
        axi.arready = 1'b1;
        @(negedge clk);
        axi.arready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_total++;
            if ({axi.arvalid, axi.rready, rsp_valid} !== 3'b010)
                $display("FAIL rd_wait%0d: got %b want 010", i, {axi.arvalid, axi.rready, rsp_valid});
            else n_pass++;
            @(negedge clk);
        end
        axi.rvalid = 1'b1;
        axi.rdata  = 32'hDEADBEEF;
        axi.rresp  = RESP_OKAY;
        @(negedge clk);
        axi.rvalid = 1'b0;
        axi.rdata  = 32'h0;
        n_total++;
        if ({rsp_valid, rsp_write, rsp_resp, axi.rready} !== 5'b10000)
            $display("FAIL rd_rsp_ctl: got %b want 10000", {rsp_valid, rsp_write, rsp_resp, axi.rready});
        else n_pass++;
        n_total++; if (rsp_rdata !== 32'hDEADBEEF) $display("FAIL rd_rdata: got %h want deadbeef", rsp_rdata);
        else n_pass++;
        finish_rsp();
    endtask

    task automatic test_same_cycle();
        send_cmd(1'b1, 12'h010, 32'h12345678, 4'h3);
        axi.awready = 1'b1;
        axi.wready  = 1'b1;
        @(negedge clk);
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        n_total++;
        if ({axi.awvalid, axi.wvalid, axi.bready} !== 3'b001)
            $display("FAIL same_aw_w: got %b want 001", {axi.awvalid, axi.wvalid, axi.bready});
        else n_pass++;
        axi.bvalid = 1'b1;
        axi.bresp  = RESP_SLVERR;
        @(negedge clk);
        axi.bvalid = 1'b0;
        axi.bresp  = RESP_OKAY;
        n_total++;
        if ({rsp_valid, rsp_resp} !== 3'b110)
            $display("FAIL same_slverr: got v%b r%h want v1 r2", rsp_valid, rsp_resp);
        else n_pass++;
        finish_rsp();
    endtask

    task automatic test_timeout();
        int n;
        n = 0;
        send_cmd(1'b0, 12'h0FC, 32'h0, 4'h0);
        while (axi.arvalid === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        n_total++; if (n != 16) $display("FAIL to_arvalid_cycles: got %0d want 16", n);
        else n_pass++;
        n_total++;
        if ({rsp_valid, rsp_resp, axi.rready} !== 4'b1110)
            $display("FAIL to_rsp: got v%b r%h rr%b want v1 r3 rr0", rsp_valid, rsp_resp, axi.rready);
        else n_pass++;
        n_total++; if (rsp_rdata !== 32'h0) $display("FAIL to_rdata: got %h want 0", rsp_rdata);
        else n_pass++;
        // A late read beat must not disturb the pending DECERR response.
        axi.rvalid = 1'b1;
        axi.rdata  = 32'hAAAA5555;
        @(negedge clk);
        axi.rvalid = 1'b0;
        axi.rdata  = 32'h0;
        n_total++;
        if ({rsp_valid, rsp_resp, rsp_rdata, axi.rready} !== {1'b1, 2'b11, 32'h0, 1'b0})
            $display("FAIL to_late_r: got v%b r%h d%h rr%b", rsp_valid, rsp_resp, rsp_rdata, axi.rready);
        else n_pass++;
        finish_rsp();
    endtask

    task automatic test_back_pressure();
        send_cmd(1'b1, 12'h020, 32'h00C0FFEE, 4'h1);
        axi.awready = 1'b1;
        axi.wready  = 1'b1;
        @(negedge clk);
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        axi.bvalid  = 1'b1;
        axi.bresp   = RESP_OKAY;
        @(negedge clk);
        axi.bvalid = 1'b0;
        // Next command waits while the response is stalled.
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 12'h030;
        for (int i = 0; i < 5; i++) begin
            n_total++;
            if ({rsp_valid, rsp_write, rsp_resp, rsp_rdata, cmd_ready, axi.arvalid} !==
                {2'b11, 2'b00, 32'h0, 2'b00})
                $display("FAIL bp_hold%0d: got v%b w%b r%h d%h cr%b ar%b", i, rsp_valid, rsp_write,
                         rsp_resp, rsp_rdata, cmd_ready, axi.arvalid);
            else n_pass++;
            @(negedge clk);
        end
        finish_rsp();
        n_total++;
        if ({rsp_valid, cmd_ready, axi.arvalid} !== 3'b010)
            $display("FAIL bp_release: got %b want 010", {rsp_valid, cmd_ready, axi.arvalid});
        else n_pass++;
        @(negedge clk);
        cmd_valid = 1'b0;
        n_total++;
        if ({axi.arvalid, axi.araddr, cmd_ready} !== {1'b1, 12'h030, 1'b0})
            $display("FAIL bp_next_cmd: got ar%b a%h cr%b want ar1 a030 cr0",
                     axi.arvalid, axi.araddr, cmd_ready);
        else n_pass++;
        axi.arready = 1'b1;
        @(negedge clk);
        axi.arready = 1'b0;
        axi.rvalid  = 1'b1;
        axi.rdata   = 32'h0BADF00D;
        axi.rresp   = RESP_OKAY;
        @(negedge clk);
        axi.rvalid = 1'b0;
        axi.rdata  = 32'h0;
        n_total++;
        if ({rsp_valid, rsp_rdata} !== {1'b1, 32'h0BADF00D})
            $display("FAIL bp_read_data: got v%b d%h want v1 0badf00d", rsp_valid, rsp_rdata);
        else n_pass++;
        finish_rsp();
    endtask

    task automatic test_reset_mid();
        logic [4:0] vr;
        send_cmd(1'b1, 12'h040, 32'h55AA55AA, 4'hF);
        axi.awready = 1'b1;
        axi.wready  = 1'b1;
        @(negedge clk);
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        n_total++; if (axi.bready !== 1'b1) $display("FAIL rm_in_wr_b: got %b want 1", axi.bready);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        vr = {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready};
        n_total++;
        if ({vr, rsp_valid, cmd_ready} !== 7'b0)
            $display("FAIL rm_async: got vr%b rv%b cr%b want all 0", vr, rsp_valid, cmd_ready);
        else n_pass++;
        axi.bvalid = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        axi.bvalid = 1'b0;
        n_total++;
        if ({cmd_ready, rsp_valid, axi.bready} !== 3'b100)
            $display("FAIL rm_release: got %b want 100", {cmd_ready, rsp_valid, axi.bready});
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_total++; if (rsp_valid !== 1'b0) $display("FAIL rm_no_rsp%0d: got %b want 0", i, rsp_valid);
            else n_pass++;
        end
    endtask

    initial begin
        cmd_valid   = 1'b0;
        cmd_write   = 1'b0;
        cmd_addr    = '0;
        cmd_wdata   = '0;
        cmd_wstrb   = '0;
        rsp_ready   = 1'b0;
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        axi.bvalid  = 1'b0;
        axi.bresp   = 2'b00;
        axi.arready = 1'b0;
        axi.rvalid  = 1'b0;
        axi.rdata   = '0;
        axi.rresp   = 2'b00;
        test_reset();
        test_write();
        test_read();
        test_same_cycle();
        test_timeout();
        test_back_pressure();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
